// File: rtl/dut_param_pkg.sv
// dut_param_pkg: shared constants, FSM state encoding and threshold array type for histo_th_calc.
// Rev 1.0
`default_nettype none

package dut_param_pkg;

  localparam int p_depth_bit        = 8;
  localparam int p_histo_sram_d_bit = 10;
  localparam int p_depth_size_bit   = 10;
  localparam int p_th_num           = 7;
  localparam int p_depth_qnt_bit    = 3;

  typedef logic [p_th_num-1:0][p_depth_bit-1:0] th_arr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } histo_th_state_t;

endpackage

`default_nettype wire

// File: rtl/histo_th_slice.sv
// histo_th_slice: one threshold - target register, compare, capture-once flag and bin register.
// Rev 1.0
`default_nettype none

module histo_th_slice
  import dut_param_pkg::*;
#(
  parameter int P_DEPTH_BIT = p_depth_bit,
  parameter int P_PIX_W     = p_depth_size_bit + 1,
  parameter int P_SUM_W     = p_histo_sram_d_bit + p_depth_bit,
  parameter int P_QNT_BIT   = p_depth_qnt_bit,
  parameter int P_K         = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clr,
  input  logic                   i_vld,
  input  logic [P_PIX_W-1:0]     i_pix_num,
  input  logic [P_DEPTH_BIT-1:0] i_bin,
  input  logic [P_SUM_W-1:0]     i_sum,
  output logic [P_DEPTH_BIT-1:0] o_th,
  output logic                   o_found
);

  localparam int c_prod_w = P_PIX_W + P_QNT_BIT;
  localparam int c_cmp_w  = (P_SUM_W > c_prod_w) ? P_SUM_W : c_prod_w;

  logic [c_prod_w-1:0]    w_prod;
  logic [c_prod_w-1:0]    r_target;
  logic [P_DEPTH_BIT-1:0] r_th;
  logic                   r_hit;
  logic                   w_hit_now;

  assign w_prod    = c_prod_w'(P_K) * c_prod_w'(i_pix_num);
  assign w_hit_now = i_vld && !r_hit && (c_cmp_w'(i_sum) >= c_cmp_w'(r_target));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_target <= '0;
      r_th     <= '0;
      r_hit    <= 1'b0;
    end else if (i_clr) begin
      r_target <= w_prod >> P_QNT_BIT;
      r_th     <= '1;
      r_hit    <= 1'b0;
    end else if (w_hit_now) begin
      r_th  <= i_bin;
      r_hit <= 1'b1;
    end
  end

  // Includes the same-cycle hit so the top can react to the bin that completes the set.
  assign o_found = r_hit | w_hit_now;
  assign o_th    = r_th;

endmodule

`default_nettype wire

// File: rtl/histo_th_calc.sv
// histo_th_calc: scans a 256-bin histogram SRAM and derives P_TH_NUM cumulative-count thresholds.
// Rev 1.0 - optional macro HISTO_TH_EARLY_EXIT_EN stops the scan once every threshold is captured.
`default_nettype none

module histo_th_calc
  import dut_param_pkg::*;
#(
  parameter int P_DEPTH_BIT      = p_depth_bit,
  parameter int P_HISTO_D_BIT    = p_histo_sram_d_bit,
  parameter int P_DEPTH_SIZE_BIT = p_depth_size_bit,
  parameter int P_TH_NUM         = p_th_num
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [P_DEPTH_SIZE_BIT:0]       pix_num,
  output logic [P_DEPTH_BIT-1:0]          histo_sram_a,
  output logic                            histo_sram_rd,
  input  logic [P_HISTO_D_BIT-1:0]        histo_sram_q,
  output logic [P_TH_NUM*P_DEPTH_BIT-1:0] th,
  output logic                            th_vld,
  output logic                            busy,
  output logic                            done
);

  localparam int c_qnt_bit = $clog2(P_TH_NUM + 1);
  localparam int c_sum_w   = P_HISTO_D_BIT + P_DEPTH_BIT;
  localparam logic [P_DEPTH_BIT-1:0] c_last_bin = '1;

  histo_th_state_t        r_state, w_state_nxt;
  logic [P_DEPTH_BIT-1:0] r_addr, r_bin;
  logic                   r_dvld, r_th_vld, r_all_found;
  logic [c_sum_w-1:0]     r_cum, w_sum;
  logic                   w_start, w_acc, w_all_found;
  logic [P_TH_NUM-1:0]    w_found;

  assign w_start     = (r_state == IDLE) && start;
  assign w_sum       = r_cum + c_sum_w'(histo_sram_q);
  assign w_all_found = &w_found;
  // Data returned after every threshold is captured (early-exit spill read) is dropped.
  assign w_acc       = r_dvld && !r_all_found && ((r_state == READ) || (r_state == DRAIN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (w_start) w_state_nxt = READ;
      READ: begin
`ifdef HISTO_TH_EARLY_EXIT_EN
        if (w_all_found)                 w_state_nxt = DONE;
        else if (r_addr == c_last_bin)   w_state_nxt = DRAIN;
`else
        if (r_addr == c_last_bin)        w_state_nxt = DRAIN;
`endif
      end
      DRAIN: w_state_nxt = DONE;
      DONE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_bin       <= '0;
      r_dvld      <= 1'b0;
      r_cum       <= '0;
      r_th_vld    <= 1'b0;
      r_all_found <= 1'b0;
    end else begin
      r_dvld <= (r_state == READ);
      r_bin  <= r_addr;
      if (w_start) begin
        r_addr      <= '0;
        r_cum       <= '0;
        r_th_vld    <= 1'b0;
        r_all_found <= 1'b0;
      end else begin
        if (r_state == READ)       r_addr   <= r_addr + P_DEPTH_BIT'(1);
        if (w_acc)                 r_cum    <= w_sum;
        if (w_state_nxt == DONE)   r_th_vld <= 1'b1;
        r_all_found <= w_all_found;
      end
    end
  end

  for (genvar gi = 0; gi < P_TH_NUM; gi++) begin : g_slice
    histo_th_slice #(
      .P_DEPTH_BIT (P_DEPTH_BIT),
      .P_PIX_W     (P_DEPTH_SIZE_BIT + 1),
      .P_SUM_W     (c_sum_w),
      .P_QNT_BIT   (c_qnt_bit),
      .P_K         (gi + 1)
    ) u_slice (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clr     (w_start),
      .i_vld     (w_acc),
      .i_pix_num (pix_num),
      .i_bin     (r_bin),
      .i_sum     (w_sum),
      .o_th      (th[(gi+1)*P_DEPTH_BIT-1 -: P_DEPTH_BIT]),
      .o_found   (w_found[gi])
    );
  end

  assign histo_sram_a  = r_addr;
  assign histo_sram_rd = (r_state == READ);
  assign busy          = (r_state != IDLE);
  assign done          = (r_state == DONE);
  assign th_vld        = r_th_vld;

endmodule

`default_nettype wire

// File: tb/tb_histo_th_calc.sv
// tb_histo_th_calc: directed, table-driven self-checking bench for histo_th_calc.
// Rev 1.0
`default_nettype none

module tb_histo_th_calc;
  import dut_param_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [10:0] pix_num = '0;
  logic [7:0]  histo_sram_a;
  logic        histo_sram_rd;
  logic [9:0]  histo_sram_q = '0;
  logic [55:0] th;
  logic        th_vld, busy, done;

  logic [9:0]  mem [256];
  int checks = 0;
  int failures = 0;

  int   g_done, g_ndone, g_busy;
  logic g_rd1, g_vld1, g_rd256, g_vld_done;
  logic [7:0] g_a1, g_a256;

`ifdef HISTO_TH_EARLY_EXIT_EN
  localparam int D_UNI = 226, D_SPK = 103, D_ZERO = 3, D_HALF = 258, D_BIN0 = 3, D_TWO = 63;
`else
  localparam int D_UNI = 258, D_SPK = 258, D_ZERO = 258, D_HALF = 258, D_BIN0 = 258, D_TWO = 258;
`endif

  typedef struct {
    int          pat;
    logic [10:0] pix;
    th_arr_t     th;
    int          done_c;
  } vec_t;
  vec_t vecs[6];

  histo_th_calc dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .pix_num      (pix_num),
    .histo_sram_a (histo_sram_a),
    .histo_sram_rd(histo_sram_rd),
    .histo_sram_q (histo_sram_q),
    .th           (th),
    .th_vld       (th_vld),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // One-cycle read latency; junk on idle cycles exposes stray accumulation.
  always @(posedge clk) histo_sram_q <= histo_sram_rd ? mem[histo_sram_a] : 10'h2AA;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic load_pat(input int pat);
    for (int i = 0; i < 256; i++) begin
      logic [9:0] v;
      v = '0;
      case (pat)
        0: v = 10'd4;
        1: v = (i == 100) ? 10'd1023 : ((i == 200) ? 10'd1 : 10'd0);
        3: v = (i < 128) ? 10'd4 : 10'd0;
        4: v = (i == 0) ? 10'd1023 : 10'd0;
        5: v = (i == 50 || i == 60) ? 10'd512 : 10'd0;
        default: v = '0;
      endcase
      mem[i] = v;
    end
  endtask

  task automatic run_scan(input int pat, input logic [10:0] pix, input int p1, input int p2);
    load_pat(pat);
    pix_num = pix;
    g_done = -1; g_ndone = 0; g_busy = 0; g_vld_done = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (cyc == 1)   begin g_rd1 = histo_sram_rd; g_a1 = histo_sram_a; g_vld1 = th_vld; end
      if (cyc == 256) begin g_rd256 = histo_sram_rd; g_a256 = histo_sram_a; end
      if (done) begin
        g_ndone++;
        if (g_done < 0) begin g_done = cyc; g_vld_done = th_vld; end
      end
      if (busy) g_busy++;
      start = (cyc == p1) || (cyc == p2);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_th"},     64'(th), 64'd0);
    chk({tag, "_th_vld"}, 64'(th_vld), 64'd0);
    chk({tag, "_busy"},   64'(busy), 64'd0);
    chk({tag, "_done"},   64'(done), 64'd0);
    chk({tag, "_rd"},     64'(histo_sram_rd), 64'd0);
    chk({tag, "_addr"},   64'(histo_sram_a), 64'd0);
  endtask

  initial begin
    int nd, nb;
    vecs[0] = '{0, 11'd1024, th_arr_t'({8'd223, 8'd191, 8'd159, 8'd127, 8'd95, 8'd63, 8'd31}), D_UNI};
    vecs[1] = '{1, 11'd1024, th_arr_t'({7{8'd100}}), D_SPK};
    vecs[2] = '{2, 11'd0,    th_arr_t'(56'd0), D_ZERO};
    vecs[3] = '{3, 11'd1024, th_arr_t'({8'd255, 8'd255, 8'd255, 8'd127, 8'd95, 8'd63, 8'd31}), D_HALF};
    vecs[4] = '{4, 11'd1023, th_arr_t'(56'd0), D_BIN0};
    vecs[5] = '{5, 11'd1024, th_arr_t'({8'd60, 8'd60, 8'd60, 8'd50, 8'd50, 8'd50, 8'd50}), D_TWO};

    repeat (2) @(negedge clk);
    chk_reset_outputs("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_scan(vecs[i].pat, vecs[i].pix, 0, 0);
      chk($sformatf("v%0d_th", i),        64'(th), 64'(vecs[i].th));
      chk($sformatf("v%0d_done_cyc", i),  64'(g_done), 64'(vecs[i].done_c));
      chk($sformatf("v%0d_done_cnt", i),  64'(g_ndone), 64'd1);
      chk($sformatf("v%0d_busy_cyc", i),  64'(g_busy), 64'(vecs[i].done_c));
      chk($sformatf("v%0d_vld_at_done", i), 64'(g_vld_done), 64'd1);
      chk($sformatf("v%0d_vld_hold", i),  64'(th_vld), 64'd1);
      chk($sformatf("v%0d_vld_clr", i),   64'(g_vld1), 64'd0);
      chk($sformatf("v%0d_rd_c1", i),     64'({g_rd1, g_a1}), 64'({1'b1, 8'd0}));
      chk($sformatf("v%0d_rd_c256", i),   64'(g_rd256), 64'(vecs[i].done_c == 258));
      if (vecs[i].done_c == 258) chk($sformatf("v%0d_a_c256", i), 64'(g_a256), 64'd255);
    end

    // Reset in the middle of a scan.
    load_pat(0);
    pix_num = 11'd1024;
    nd = 0; nb = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc < 100; cyc++) begin
      if (done) nd++;
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done) nd++;
      if (busy) nb++;
    end
    chk("midrst_no_done", 64'(nd), 64'd0);
    chk("midrst_idle", 64'(nb), 64'd0);
    run_scan(0, 11'd1024, 0, 0);
    chk("rerun_th",       64'(th), 64'(vecs[0].th));
    chk("rerun_done_cyc", 64'(g_done), 64'(D_UNI));
    chk("rerun_vld",      64'(th_vld), 64'd1);

    // Start pulses while busy, including the done cycle, are ignored.
    run_scan(1, 11'd1024, 50, D_SPK);
    chk("ign_th",       64'(th), 64'(vecs[1].th));
    chk("ign_done_cnt", 64'(g_ndone), 64'd1);
    chk("ign_done_cyc", 64'(g_done), 64'(D_SPK));
    chk("ign_busy_cyc", 64'(g_busy), 64'(D_SPK));
    chk("ign_vld_hold", 64'(th_vld), 64'd1);
    run_scan(3, 11'd1024, 0, 0);
    chk("next_vld_clr", 64'(g_vld1), 64'd0);
    chk("next_th",      64'(th), 64'(vecs[3].th));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
